// File: rtl/srec_emitter_pkg.sv
// ----------------------------------------------------------------------------
// srec_emitter_pkg
// Shared definitions for the Motorola S-record emitter: FSM state encoding,
// record character constants, the per-record byte limit and small helpers
// (nibble-to-ASCII conversion, record chunk sizing).
// No ports; imported by srec_emitter.
// ----------------------------------------------------------------------------
package srec_emitter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_TYPE = 4'd1,
    ST_CNT  = 4'd2,
    ST_ADDR = 4'd3,
    ST_RD   = 4'd4,
    ST_DATA = 4'd5,
    ST_SUM  = 4'd6,
    ST_EOL  = 4'd7,
    ST_FIN  = 4'd8
  } state_t;

  localparam logic [7:0] CH_S   = 8'h53;  // 'S'
  localparam logic [7:0] CH_3   = 8'h33;  // '3'
  localparam logic [7:0] CH_7   = 8'h37;  // '7'
  localparam logic [7:0] CH_EOL = 8'h0A;  // line feed

  localparam int MAX_REC_BYTES = 16;

  // Upper-case ASCII hex digit for one nibble.
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h37 + {4'h0, nib};
    end
  endfunction

  // Data bytes carried by the next S3 record: min(MAX_REC_BYTES, remaining).
  function automatic logic [4:0] rec_len(input logic [15:0] rem);
    if (rem > 16'(MAX_REC_BYTES)) begin
      return 5'(MAX_REC_BYTES);
    end else begin
      return rem[4:0];
    end
  endfunction

endpackage

// File: rtl/srec_emitter.sv
// ----------------------------------------------------------------------------
// srec_emitter
// Reads a byte region from memory and streams it as S3 records (max 16 data
// bytes each) followed by a single S7 termination record.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, base_addr, length   dump request (sampled in IDLE only)
//   busy, done                 status; done pulses once per dump
//   mem_address, mem_access_size, mem_rw, mem_en, mem_data_out
//                              byte read port, data returned 1 cycle after en
//   char_out, char_valid, char_ready
//                              ASCII stream with valid/ready handshake
// ----------------------------------------------------------------------------
module srec_emitter
  import srec_emitter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] length,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_access_size,
  output logic        mem_rw,
  output logic        mem_en,
  input  logic [7:0]  mem_data_out,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready
);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_idx;       // character index within the current field
  logic        r_rd_ph;     // 0: strobe cycle, 1: data-capture cycle
  logic        r_s7;        // current record is the S7 terminator
  logic [31:0] r_base;
  logic [31:0] r_addr;      // next byte address to read
  logic [31:0] r_rec_addr;  // address field of the current record
  logic [15:0] r_remain;
  logic [4:0]  r_n;         // data bytes in the current record
  logic [4:0]  r_done_cnt;  // data bytes already emitted in this record
  logic [7:0]  r_sum;
  logic [7:0]  r_byte;
  logic        w_acc;
  logic [7:0]  w_count;
  logic [3:0]  w_nib;

  assign w_acc           = char_valid & char_ready;
  assign w_count         = r_s7 ? 8'h05 : (8'h05 + {3'b000, r_n});
  assign mem_address     = r_addr;
  assign mem_access_size = 2'b00;
  assign mem_rw          = 1'b0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; field transitions happen on acceptance of the last char.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_TYPE; else w_next = ST_IDLE;
      ST_TYPE: if (w_acc && r_idx == 3'd1) w_next = ST_CNT; else w_next = ST_TYPE;
      ST_CNT:  if (w_acc && r_idx == 3'd1) w_next = ST_ADDR; else w_next = ST_CNT;
      ST_ADDR: begin
        if (w_acc && r_idx == 3'd7) w_next = r_s7 ? ST_SUM : ST_RD;
        else                        w_next = ST_ADDR;
      end
      ST_RD:   if (r_rd_ph) w_next = ST_DATA; else w_next = ST_RD;
      ST_DATA: begin
        if (w_acc && r_idx == 3'd1) w_next = ((r_done_cnt + 5'd1) == r_n) ? ST_SUM : ST_RD;
        else                        w_next = ST_DATA;
      end
      ST_SUM:  if (w_acc && r_idx == 3'd1) w_next = ST_EOL; else w_next = ST_SUM;
      ST_EOL:  if (w_acc) w_next = r_s7 ? ST_FIN : ST_TYPE; else w_next = ST_EOL;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: counters, checksum accumulator, record setup and byte capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= 3'd0;
      r_rd_ph    <= 1'b0;
      r_s7       <= 1'b0;
      r_base     <= 32'd0;
      r_addr     <= 32'd0;
      r_rec_addr <= 32'd0;
      r_remain   <= 16'd0;
      r_n        <= 5'd0;
      r_done_cnt <= 5'd0;
      r_sum      <= 8'd0;
      r_byte     <= 8'd0;
    end else begin
      if (w_next != r_state) r_idx <= 3'd0;
      else if (w_acc)        r_idx <= r_idx + 3'd1;
      else                   r_idx <= r_idx;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base     <= base_addr;
            r_addr     <= base_addr;
            r_rec_addr <= base_addr;
            r_remain   <= length;
            r_s7       <= (length == 16'd0);
            r_n        <= rec_len(length);
            r_done_cnt <= 5'd0;
            r_sum      <= 8'd0;
          end
        end
        ST_CNT: begin
          if (w_acc && r_idx == 3'd1) r_sum <= r_sum + w_count;
        end
        ST_ADDR: begin
          if (w_acc && r_idx == 3'd7)
            r_sum <= r_sum + r_rec_addr[31:24] + r_rec_addr[23:16]
                           + r_rec_addr[15:8]  + r_rec_addr[7:0];
        end
        ST_RD: begin
          if (r_rd_ph) begin
            r_byte   <= mem_data_out;
            r_addr   <= r_addr + 32'd1;
            r_remain <= r_remain - 16'd1;
            r_rd_ph  <= 1'b0;
          end else begin
            r_rd_ph  <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_acc && r_idx == 3'd1) begin
            r_sum      <= r_sum + r_byte;
            r_done_cnt <= r_done_cnt + 5'd1;
          end
        end
        ST_EOL: begin
          // Set up the next record: another S3 while bytes remain, else S7.
          if (w_acc && !r_s7) begin
            r_s7       <= (r_remain == 16'd0);
            r_n        <= rec_len(r_remain);
            r_rec_addr <= (r_remain == 16'd0) ? r_base : r_addr;
            r_done_cnt <= 5'd0;
            r_sum      <= 8'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from the registered state and datapath.
  always_comb begin
    busy       = (r_state != ST_IDLE);
    done       = 1'b0;
    mem_en     = 1'b0;
    char_valid = 1'b0;
    char_out   = 8'h00;
    w_nib      = 4'h0;
    case (r_state)
      ST_TYPE: begin
        char_valid = 1'b1;
        char_out   = r_idx[0] ? (r_s7 ? CH_7 : CH_3) : CH_S;
      end
      ST_CNT: begin
        char_valid = 1'b1;
        w_nib      = r_idx[0] ? w_count[3:0] : w_count[7:4];
        char_out   = nib2ascii(w_nib);
      end
      ST_ADDR: begin
        char_valid = 1'b1;
        w_nib      = r_rec_addr[{3'd7 - r_idx, 2'b00} +: 4];
        char_out   = nib2ascii(w_nib);
      end
      ST_RD: begin
        mem_en = !r_rd_ph;
      end
      ST_DATA: begin
        char_valid = 1'b1;
        w_nib      = r_idx[0] ? r_byte[3:0] : r_byte[7:4];
        char_out   = nib2ascii(w_nib);
      end
      ST_SUM: begin
        char_valid = 1'b1;
        w_nib      = r_idx[0] ? ~r_sum[3:0] : ~r_sum[7:4];
        char_out   = nib2ascii(w_nib);
      end
      ST_EOL: begin
        char_valid = 1'b1;
        char_out   = CH_EOL;
      end
      ST_FIN: begin
        done = 1'b1;
      end
      default: begin
        busy = (r_state != ST_IDLE);
      end
    endcase
  end

endmodule

// File: tb/tb_srec_emitter.sv
// ----------------------------------------------------------------------------
// tb_srec_emitter
// Scoreboard bench: expected characters and read addresses are queued when a
// dump is requested; a negedge monitor compares everything the DUT presents.
// ----------------------------------------------------------------------------
module tb_srec_emitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [15:0] length = 16'd0;
  logic        busy, done, mem_rw, mem_en, char_valid;
  logic [31:0] mem_address;
  logic [1:0]  mem_access_size;
  logic [7:0]  mem_data_out = 8'h00;
  logic [7:0]  char_out;
  logic        char_ready = 1'b1;

  logic [7:0]  mem [256];
  logic [7:0]  exp_q [$];
  logic [31:0] rd_q [$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_acc = 0;
  bit          rand_mode = 1'b0;

  srec_emitter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .mem_address(mem_address),
    .mem_access_size(mem_access_size), .mem_rw(mem_rw), .mem_en(mem_en),
    .mem_data_out(mem_data_out), .char_out(char_out),
    .char_valid(char_valid), .char_ready(char_ready)
  );

  always #5 clk = ~clk;

  // Byte memory with one cycle of read latency; junk when not strobed.
  always @(posedge clk) begin
    if (mem_en) mem_data_out <= mem[mem_address[7:0]];
    else        mem_data_out <= 8'h5A;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Sink ready: always 1, or random per cycle in backpressure mode.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      char_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: character scoreboard, stall stability and read-address check.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_char;
    prev_stall = 1'b0;
    prev_char  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (char_valid) begin
          if (prev_stall) check("stall_hold", char_out, prev_char);
          if (char_ready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL char_extra: got %h expected none at %0t", char_out, $time);
            end else begin
              check("char", char_out, exp_q.pop_front());
            end
          end
          prev_stall = !char_ready;
          prev_char  = char_out;
        end else begin
          prev_stall = 1'b0;
        end
        if (mem_en) begin
          if (rd_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rd_extra: got %h expected none at %0t", mem_address, $time);
          end else begin
            check("rd_addr", mem_address, rd_q.pop_front());
          end
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_char_valid", char_valid, 0);
    check("rst_char_out", char_out, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_size_rw", {mem_access_size, mem_rw}, 0);
  endtask

  // Issue one dump and wait for done; exp_cyc < 0 skips the latency check.
  task automatic run_region(input logic [31:0] b, input logic [15:0] l, input int exp_cyc);
    int cyc;
    bit got;
    @(posedge clk); #1;
    base_addr = b; length = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = ~b; length = 16'hFFFF;
    check("first_valid", char_valid, 1);
    check("busy_on", busy, 1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 3000) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
        start = (cyc == 5);
      end
    end
    start = 1'b0;
    check("done_seen", got, 1);
    if (exp_cyc >= 0) check("latency", cyc, exp_cyc);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("busy_off", busy, 0);
    check("stream_left", exp_q.size(), 0);
    check("reads_left", rd_q.size(), 0);
  endtask

  initial begin
    int w;
    // Reset state
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic record: 3 bytes at 0x100
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h02; mem[8'h02] = 8'h03;
    for (int i = 0; i < 3; i++) rd_q.push_back(32'h100 + i);
    push_str("S30800000100010203F0\n");
    push_str("S70500000100F9\n");
    run_region(32'h0000_0100, 16'd3, 42);

    // Empty region: only S7, no reads
    push_str("S70500000100F9\n");
    run_region(32'h0000_0100, 16'd0, 15);

    // Record split: 17 bytes at 0, mem[i] = i
    for (int i = 0; i < 17; i++) mem[i] = 8'(i);
    for (int i = 0; i < 17; i++) rd_q.push_back(32'(i));
    push_str("S31500000000000102030405060708090A0B0C0D0E0F72\n");
    push_str("S3060000001010D9\n");
    push_str("S70500000000FA\n");
    run_region(32'h0, 16'd17, -1);

    // Backpressure: same stream with random ready
    rand_mode = 1'b1;
    for (int i = 0; i < 17; i++) rd_q.push_back(32'(i));
    push_str("S31500000000000102030405060708090A0B0C0D0E0F72\n");
    push_str("S3060000001010D9\n");
    push_str("S70500000000FA\n");
    run_region(32'h0, 16'd17, -1);
    rand_mode = 1'b0;

    // Address wrap
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC;
    rd_q.push_back(32'hFFFF_FFFE); rd_q.push_back(32'hFFFF_FFFF); rd_q.push_back(32'h0);
    push_str("S308FFFFFFFEAABBCCCB\n");
    push_str("S705FFFFFFFEFF\n");
    run_region(32'hFFFF_FFFE, 16'd3, -1);

    // Reset in the middle of the data field
    for (int i = 0; i < 17; i++) mem[i] = 8'(i);
    for (int i = 0; i < 17; i++) rd_q.push_back(32'(i));
    push_str("S31500000000000102030405060708090A0B0C0D0E0F72\n");
    n_acc = 0;
    @(posedge clk); #1;
    base_addr = 32'h0; length = 16'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!(n_acc >= 20 && char_valid) && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("mid_data_reached", (w < 500), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    rd_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Full run after reset
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h02; mem[8'h02] = 8'h03;
    for (int i = 0; i < 3; i++) rd_q.push_back(32'h100 + i);
    push_str("S30800000100010203F0\n");
    push_str("S70500000100F9\n");
    run_region(32'h0000_0100, 16'd3, 42);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/srec_emitter.md
SREC_EMITTER -- requirements
Module: srec_emitter

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle request to dump a memory region; sampled only in IDLE.
REQ-004 base_addr  input  32  first byte address of the region; sampled with start.
REQ-005 length  input  16  byte count of the region (0 legal); sampled with start.
REQ-006 busy  output  1  high from the cycle after start is accepted until done.
REQ-007 done  output  1  one-cycle pulse after the final character is accepted.
REQ-008 mem_address  output  32  byte read address.
REQ-009 mem_access_size  output  2  fixed 2'b00 (byte).
REQ-010 mem_rw  output  1  fixed 0 (read); never writes.
REQ-011 mem_en  output  1  read strobe; one cycle per byte.
REQ-012 mem_data_out  input  8  read data, valid exactly 1 cycle after mem_en.
REQ-013 char_out  output  8  ASCII character stream.
REQ-014 char_valid  output  1  char_out holds a valid character.
REQ-015 char_ready  input  1  sink accepts char_out when char_valid and char_ready are both high at a rising edge.

Function
REQ-016 Emits the region as S3 records of at most 16 data bytes, followed by one S7 record; each record ends with 0x0A.
REQ-017 Record format: 'S', type digit, 2-hex count, 8-hex address, 2 hex per data byte, 2-hex checksum, 0x0A; hex is upper-case '0'-'9','A'-'F', high nibble first.
REQ-018 S3 count = 4 + N + 1, where N = min(16, remaining bytes); record address = base_addr + bytes already emitted, modulo 2^32.
REQ-019 Checksum = bitwise NOT of the low 8 bits of the sum of the count byte, the four address bytes and all data bytes.
REQ-020 S7 record: count 05, address = base_addr, checksum per REQ-019, no data.
REQ-021 length = 0: only the S7 record is emitted.
REQ-022 FSM states: IDLE, TYPE, CNT, ADDR, RD, DATA, SUM, EOL, FIN; TYPE emits 'S' and the type digit.
REQ-023 Transitions: IDLE->TYPE on start; TYPE->CNT->ADDR; ADDR->RD (N>0) or SUM (S7).
REQ-024 Transitions continue: RD->DATA; DATA->RD until N bytes have been emitted, then ->SUM->EOL.
REQ-025 Transitions end: EOL->TYPE while bytes remain or S7 is pending; EOL->FIN after the S7 line; FIN->IDLE with done.
REQ-026 RD: mem_en high for one cycle; the byte is latched the following cycle; no character is presented during the read.
REQ-027 Each character advances only on acceptance; char_out is stable while char_valid=1 and char_ready=0.
REQ-028 First char_valid ('S') is asserted 1 cycle after start is accepted.
REQ-029 With char_ready held high: each character takes 1 cycle, plus 2 cycles of read latency per data byte.
REQ-030 start while busy is ignored; base_addr/length changes while busy have no effect.
REQ-031 The remaining-byte counter is 16 bits; the address counter is 32 bits and wraps from FFFFFFFF to 00000000.

Reset
REQ-032 rst_n low at any time forces IDLE, including mid-record; no partial-record resumption.
REQ-033 While reset is asserted: busy, done, mem_en, char_valid = 0; char_out, mem_address = 0; mem_access_size = 00; mem_rw = 0.
REQ-034 Internal counters and the checksum accumulator clear on reset.

Structure
REQ-035 A shared package holds the state enum, record-type chars ('S','3','7'), EOL (0x0A), MAX_REC_BYTES (16), and the nibble-to-ASCII function.
REQ-036 Single module; no sub-module.

Verification
REQ-037 Basic record: base 0x00000100, length 3, mem 01 02 03 -> "S30800000100010203F0\n" then "S70500000100F9\n", then done.
REQ-038 Empty region: length 0, base 0x00000100 -> only "S70500000100F9\n"; mem_en never asserts.
REQ-039 Record split: length 17, base 0 -> first record count 15 at address 00000000 with 16 bytes; second record count 06 at address 00000010 with 1 byte; then S7.
REQ-040 Backpressure: random char_ready -> byte-identical stream to the char_ready=1 run; char_out never changes while stalled.
REQ-041 Address wrap: base 0xFFFFFFFE, length 3 -> reads at FFFFFFFE, FFFFFFFF, 00000000; record address field FFFFFFFE.
REQ-042 Reset mid-DATA: all outputs are per REQ-033; a subsequent start yields a complete, correct stream.
